// File: rtl/fusion_axil_regs.sv
// fusion_axil_regs: AXI4-Lite control/status register file for the sensor fusion accelerator.
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*     : write address, data and response channels
//   s_axi_ar*/r*        : read address and data channels
//   kalman_valid        : per-sample strobe counted into SAMPLE_CNT
//   imu_enable          : IMU_CTRL bit 0
//   lidar_enable        : LIDAR_CTRL bit 0
module fusion_axil_regs #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    input  logic                kalman_valid,
    output logic                imu_enable,
    output logic                lidar_enable
);
    logic                aw_held, w_held;
    logic [1:0]          aw_idx;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic [DATA_W-1:0]   sample_cnt, scratch, rd_mux;
    logic                aw_hs, w_hs, ar_hs, commit;
    logic                unused_bits;

    // Only addr[3:2] decodes; the remaining address bits are deliberately ignored.
    assign unused_bits = ^{s_axi_awaddr, s_axi_araddr};

    assign s_axi_awready = !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = !w_held && !s_axi_bvalid;
    assign s_axi_arready = !s_axi_rvalid;
    assign s_axi_rresp   = 2'b00;
    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = aw_held && w_held;

    always_comb begin
        rd_mux = s_axi_araddr[3:2] == 2'd0 ? {{(DATA_W-1){1'b0}}, imu_enable} :
                 s_axi_araddr[3:2] == 2'd1 ? {{(DATA_W-1){1'b0}}, lidar_enable} :
                 s_axi_araddr[3:2] == 2'd2 ? sample_cnt : scratch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx       <= 2'd0;
            w_data       <= '0;
            w_strb       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi_awaddr[3:2];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= aw_idx == 2'd2 ? 2'b10 : 2'b00;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imu_enable   <= 1'b0;
            lidar_enable <= 1'b0;
            scratch      <= '0;
            sample_cnt   <= '0;
        end else begin
            if (commit && aw_idx == 2'd0 && w_strb[0]) imu_enable <= w_data[0];
            if (commit && aw_idx == 2'd1 && w_strb[0]) lidar_enable <= w_data[0];
            for (int i = 0; i < DATA_W/8; i++)
                if (commit && aw_idx == 2'd3 && w_strb[i]) scratch[8*i +: 8] <= w_data[8*i +: 8];
            // SAMPLE_CNT is read-only: bus writes never touch it, only the strobe does.
            sample_cnt <= sample_cnt + {{(DATA_W-1){1'b0}}, kalman_valid};
        end
    end

    // rd_mux reflects pre-edge register values, so a read sees the old value on a same-edge update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
        end else if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_mux;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fusion_axil_regs.sv
// tb_fusion_axil_regs: table-driven and directed-sequence bench for fusion_axil_regs.
module tb_fusion_axil_regs;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, imu_enable, lidar_enable;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        kalman_valid = 1'b0;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    fusion_axil_regs dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .kalman_valid(kalman_valid), .imu_enable(imu_enable), .lidar_enable(lidar_enable)
    );

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        bit          imu;
        bit          lid;
    } vec_t;

    vec_t v[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timeout waiting for handshake", nm);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
        int  n = 0;
        bit  aw_acc, w_acc;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        while ((awvalid || wvalid) && n < 20) begin
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            @(negedge clk);
            if (aw_acc) awvalid = 1'b0;
            if (w_acc) wvalid = 1'b0;
            n++;
        end
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) begin
            timeout("write");
            awvalid = 1'b0; wvalid = 1'b0; r = 2'b11;
        end else begin
            r = bresp;
            @(negedge clk);
        end
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            timeout("read");
            d = 'x;
        end else begin
            d = rdata;
            @(negedge clk);
        end
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        v[0]  = '{1, 4'h0, 32'h0000_0001, 4'hF, 32'h0, 1, 0};
        v[1]  = '{1, 4'h4, 32'h0000_0001, 4'hF, 32'h0, 1, 1};
        v[2]  = '{0, 4'h0, 32'h0, 4'h0, 32'h1, 1, 1};
        v[3]  = '{0, 4'h4, 32'h0, 4'h0, 32'h1, 1, 1};
        v[4]  = '{1, 4'h0, 32'h0000_0000, 4'hF, 32'h0, 0, 1};
        v[5]  = '{0, 4'h0, 32'h0, 4'h0, 32'h0, 0, 1};
        v[6]  = '{1, 4'hC, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 1};
        v[7]  = '{1, 4'hC, 32'h1234_5678, 4'h5, 32'h0, 0, 1};
        v[8]  = '{0, 4'hC, 32'h0, 4'h0, 32'hDE34_BE78, 0, 1};
        v[9]  = '{1, 4'h0, 32'hFFFF_FFFF, 4'hE, 32'h0, 0, 1};
        v[10] = '{0, 4'h0, 32'h0, 4'h0, 32'h0, 0, 1};
        v[11] = '{0, 4'hE, 32'h0, 4'h0, 32'hDE34_BE78, 0, 1};
        v[12] = '{1, 4'h8, 32'h0, 4'hF, 32'h2, 0, 1};
        v[13] = '{0, 4'h8, 32'h0, 4'h0, 32'h0, 0, 1};
        v[14] = '{1, 4'h5, 32'h0000_0000, 4'h1, 32'h0, 0, 0};
        v[15] = '{1, 4'h7, 32'h0000_0001, 4'hF, 32'h0, 0, 1};

        #12;
        check("rst_ready", {29'd0, awready, wready, arready}, 32'h7);
        check("rst_valid", {30'd0, bvalid, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_en", {30'd0, imu_enable, lidar_enable}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (v[i].wr) begin
                axi_write(v[i].addr, v[i].data, v[i].strb, r);
                check($sformatf("vec%0d_bresp", i), {30'd0, r}, v[i].exp);
            end else begin
                axi_read(v[i].addr, d);
                check($sformatf("vec%0d_rdata", i), d, v[i].exp);
            end
            check($sformatf("vec%0d_en", i), {30'd0, imu_enable, lidar_enable}, {30'd0, v[i].imu, v[i].lid});
        end

        // W leads AW by 5 cycles; bvalid lands exactly one cycle after AW is accepted
        @(negedge clk);
        wdata = 32'hA5A5_0F0F; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        check("split_wready_low", {31'd0, wready}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("split_no_b", {31'd0, bvalid}, 32'h0);
        end
        awaddr = 4'hC; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("split_b_not_yet", {31'd0, bvalid}, 32'h0);
        @(negedge clk);
        check("split_b", {29'd0, bvalid, bresp}, 32'h4);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        axi_read(4'hC, d);
        check("split_data", d, 32'hA5A5_0F0F);

        // write-response backpressure on a SLVERR response
        @(negedge clk);
        awaddr = 4'h8; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("bp_b", {27'd0, bvalid, bresp, awready, wready}, {27'd0, 1'b1, 2'b10, 1'b0, 1'b0});
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bp_b_clear", {31'd0, bvalid}, 32'h0);

        // read-data backpressure
        araddr = 4'hC; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_r", {rvalid, arready, rdata[29:0]}, {1'b1, 1'b0, 30'h25A5_0F0F});
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("bp_r_clear", {31'd0, rvalid}, 32'h0);

        // sample counter, read-only behaviour and wrap
        for (int i = 0; i < 7; i++) begin
            kalman_valid = 1'b1;
            @(negedge clk);
            kalman_valid = 1'b0;
            @(negedge clk);
        end
        axi_read(4'h8, d);
        check("cnt7", d, 32'd7);
        axi_write(4'h8, 32'h0, 4'hF, r);
        check("cnt_slverr", {30'd0, r}, 32'h2);
        axi_read(4'h8, d);
        check("cnt7_kept", d, 32'd7);
        force dut.sample_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.sample_cnt;
        kalman_valid = 1'b1;
        @(negedge clk);
        kalman_valid = 1'b0;
        axi_read(4'h8, d);
        check("cnt_wrap", d, 32'h0);

        // reset while AW is held and W has not arrived
        @(negedge clk);
        awaddr = 4'h0; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_b", {31'd0, bvalid}, 32'h0);
        check("mid_rst_en", {30'd0, imu_enable, lidar_enable}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_no_commit", {30'd0, bvalid, imu_enable}, 32'h0);
        axi_read(4'h4, d);
        check("mid_rst_lidar", d, 32'h0);
        axi_read(4'h8, d);
        check("mid_rst_cnt", d, 32'h0);
        axi_read(4'hC, d);
        check("mid_rst_scratch", d, 32'h0);
        @(negedge clk);
        awaddr = 4'h0; awvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0;
        @(negedge clk);
        check("post_rst_b", {29'd0, bvalid, bresp}, 32'h4);
        check("post_rst_imu", {31'd0, imu_enable}, 32'h1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
